pc_sp_write_unit: RTL and testbench

PC_SP_WRITE_UNIT -- requirements
Module: pc_sp_write_unit

---
 rtl/unicycle_pkg.sv | 27 ++
 rtl/pc_next_calc.sv | 24 ++
 rtl/pc_sp_write_unit.sv | 101 ++++++++++
 tb/tb_pc_sp_write_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/unicycle_pkg.sv
// Shared encodings for the unicycle PC/SP write path: PC ops, SP ops,
// FSM states and fault codes.
package unicycle_pkg;

  // PC operation select
  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_REL  = 2'b01;
  localparam logic [1:0] PC_ABS  = 2'b10;
  localparam logic [1:0] PC_HALT = 2'b11;

  // SP operation select
  localparam logic [1:0] SP_NONE  = 2'b00;
  localparam logic [1:0] SP_SETSP = 2'b01;
  localparam logic [1:0] SP_PUSH  = 2'b10;
  localparam logic [1:0] SP_POP   = 2'b11;

  // FSM states (2'b11 is unused)
  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_HALT  = 2'b01;
  localparam logic [1:0] ST_FAULT = 2'b10;

  // Sticky fault codes
  localparam logic [1:0] FAULT_NONE      = 2'b00;
  localparam logic [1:0] FAULT_OVERFLOW  = 2'b01;
  localparam logic [1:0] FAULT_UNDERFLOW = 2'b10;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: increment, relative branch, absolute
// load, or hold for HALT. All arithmetic wraps modulo 2^16.
module pc_next_calc
  import unicycle_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [1:0]  pc_op,
  input  logic [15:0] imm,
  input  logic [15:0] data_in,
  output logic [15:0] pc_next
);

  // Select the candidate PC for the requested operation
  always_comb begin
    pc_next = pc;
    case (pc_op)
      PC_INC:  pc_next = pc + 16'h0001;
      PC_REL:  pc_next = pc + imm;
      PC_ABS:  pc_next = data_in;
      default: pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_sp_write_unit.sv
// PC/SP write unit: registered PC and SP with a RUN/HALT/FAULT FSM.
// Stack bounds are checked on PUSH/POP; a violation freezes PC and SP,
// records a sticky fault code and parks the FSM in FAULT until reset.
module pc_sp_write_unit
  import unicycle_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] STACK_BASE  = 16'hFFFF,
  parameter logic [15:0] STACK_LIMIT = 16'hF000
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        resume,
  input  logic [1:0]  pc_op,
  input  logic [1:0]  sp_op,
  input  logic [15:0] imm,
  input  logic [15:0] data_in,
  output logic [15:0] pc_out,
  output logic [15:0] sp_out,
  output logic [1:0]  state_out,
  output logic [1:0]  fault_code
);

  logic [15:0] pc_q, pc_d, pc_calc;
  logic [15:0] sp_q, sp_d;
  logic [1:0]  state_q, state_d;
  logic [1:0]  fault_q, fault_d;
  logic        push_ovf, pop_unf;

  pc_next_calc u_pc_next_calc (
    .pc      (pc_q),
    .pc_op   (pc_op),
    .imm     (imm),
    .data_in (data_in),
    .pc_next (pc_calc)
  );

  assign push_ovf = (sp_op == SP_PUSH) && (sp_q == STACK_LIMIT);
  assign pop_unf  = (sp_op == SP_POP)  && (sp_q == STACK_BASE);

  // Next-state logic: only RUN touches PC/SP; a stall freezes everything
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    state_d = state_q;
    fault_d = fault_q;
    if (!stall) begin
      case (state_q)
        ST_RUN: begin
          if (push_ovf) begin
            state_d = ST_FAULT;
            fault_d = FAULT_OVERFLOW;
          end else if (pop_unf) begin
            state_d = ST_FAULT;
            fault_d = FAULT_UNDERFLOW;
          end else begin
            pc_d = pc_calc;
            if (pc_op == PC_HALT) state_d = ST_HALT;
            case (sp_op)
              SP_SETSP: sp_d = data_in;
              SP_PUSH:  sp_d = sp_q - 16'h0001;
              SP_POP:   sp_d = sp_q + 16'h0001;
              default:  sp_d = sp_q;
            endcase
          end
        end
        ST_HALT: begin
          if (resume) state_d = ST_RUN;
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State registers; reset wins over stall, resume and every op
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      sp_q    <= STACK_BASE;
      state_q <= ST_RUN;
      fault_q <= FAULT_NONE;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  assign pc_out     = pc_q;
  assign sp_out     = sp_q;
  assign state_out  = state_q;
  assign fault_code = fault_q;

endmodule

// File: tb/tb_pc_sp_write_unit.sv
// Directed bench for pc_sp_write_unit with hand-computed expectations.
module tb_pc_sp_write_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        resume;
  logic [1:0]  pc_op;
  logic [1:0]  sp_op;
  logic [15:0] imm;
  logic [15:0] data_in;
  logic [15:0] pc_out;
  logic [15:0] sp_out;
  logic [1:0]  state_out;
  logic [1:0]  fault_code;

  int vectors;
  int miscompares;

  pc_sp_write_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .resume     (resume),
    .pc_op      (pc_op),
    .sp_op      (sp_op),
    .imm        (imm),
    .data_in    (data_in),
    .pc_out     (pc_out),
    .sp_out     (sp_out),
    .state_out  (state_out),
    .fault_code (fault_code)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] p, input logic [1:0] s,
                       input logic [15:0] i, input logic [15:0] d);
    pc_op   = p;
    sp_op   = s;
    imm     = i;
    data_in = d;
  endtask

  task automatic check(input string tag, input logic [15:0] e_pc,
                       input logic [15:0] e_sp, input logic [1:0] e_st,
                       input logic [1:0] e_fc);
    vectors++;
    assert (pc_out === e_pc) else begin
      miscompares++;
      $error("FAIL %s pc_out got %h exp %h", tag, pc_out, e_pc);
    end
    vectors++;
    assert (sp_out === e_sp) else begin
      miscompares++;
      $error("FAIL %s sp_out got %h exp %h", tag, sp_out, e_sp);
    end
    vectors++;
    assert (state_out === e_st) else begin
      miscompares++;
      $error("FAIL %s state_out got %b exp %b", tag, state_out, e_st);
    end
    vectors++;
    assert (fault_code === e_fc) else begin
      miscompares++;
      $error("FAIL %s fault_code got %b exp %b", tag, fault_code, e_fc);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; stall = 1'b0; resume = 1'b0;
    drive(2'b00, 2'b00, 16'h0000, 16'h0000);

    // Reset then three increments
    step();                check("reset",      16'h0000, 16'hFFFF, 2'b00, 2'b00);
    reset = 1'b0;
    step();                check("inc1",       16'h0001, 16'hFFFF, 2'b00, 2'b00);
    step();                check("inc2",       16'h0002, 16'hFFFF, 2'b00, 2'b00);
    step();                check("inc3",       16'h0003, 16'hFFFF, 2'b00, 2'b00);

    // Absolute, negative relative, wrap
    drive(2'b10, 2'b00, 16'h0000, 16'h0010); step(); check("abs10",  16'h0010, 16'hFFFF, 2'b00, 2'b00);
    drive(2'b01, 2'b00, 16'hFFFC, 16'h0000); step(); check("rel_neg", 16'h000C, 16'hFFFF, 2'b00, 2'b00);
    drive(2'b10, 2'b00, 16'h0000, 16'hFFFF); step(); check("absffff", 16'hFFFF, 16'hFFFF, 2'b00, 2'b00);
    drive(2'b00, 2'b00, 16'h0000, 16'h0000); step(); check("inc_wrap", 16'h0000, 16'hFFFF, 2'b00, 2'b00);

    // ABS + SETSP together, then a stalled cycle
    drive(2'b10, 2'b01, 16'h0000, 16'h1234); step(); check("abs_setsp", 16'h1234, 16'h1234, 2'b00, 2'b00);
    stall = 1'b1;
    drive(2'b00, 2'b10, 16'h0000, 16'h0000); step(); check("stall",    16'h1234, 16'h1234, 2'b00, 2'b00);
    stall = 1'b0;
    step();                                          check("inc_push", 16'h1235, 16'h1233, 2'b00, 2'b00);
    drive(2'b00, 2'b11, 16'h0000, 16'h0000); step(); check("inc_pop",  16'h1236, 16'h1234, 2'b00, 2'b00);

    // HALT with PUSH, resume behaviour
    drive(2'b11, 2'b10, 16'h0000, 16'h0000); step(); check("halt_push", 16'h1236, 16'h1233, 2'b01, 2'b00);
    stall = 1'b1; resume = 1'b1;
    step();                                          check("halt_stall_res", 16'h1236, 16'h1233, 2'b01, 2'b00);
    stall = 1'b0; resume = 1'b0;
    drive(2'b00, 2'b11, 16'h0000, 16'h0000); step(); check("halt_ops_ign", 16'h1236, 16'h1233, 2'b01, 2'b00);
    resume = 1'b1;
    step();                                          check("resume",  16'h1236, 16'h1233, 2'b00, 2'b00);
    resume = 1'b0;
    drive(2'b00, 2'b00, 16'h0000, 16'h0000); step(); check("run_again", 16'h1237, 16'h1233, 2'b00, 2'b00);

    // Overflow at STACK_LIMIT
    drive(2'b00, 2'b01, 16'h0000, 16'hF000); step(); check("setsp_lim", 16'h1238, 16'hF000, 2'b00, 2'b00);
    drive(2'b00, 2'b10, 16'h0000, 16'h0000); step(); check("push_ovf", 16'h1238, 16'hF000, 2'b10, 2'b01);
    resume = 1'b1;
    drive(2'b00, 2'b11, 16'h0000, 16'h0000); step(); check("fault_hold", 16'h1238, 16'hF000, 2'b10, 2'b01);
    drive(2'b10, 2'b01, 16'h0000, 16'h5555); step(); check("fault_hold2", 16'h1238, 16'hF000, 2'b10, 2'b01);

    // Reset out of FAULT beats stall/resume/ops
    reset = 1'b1; stall = 1'b1;
    step();                                          check("reset_fault", 16'h0000, 16'hFFFF, 2'b00, 2'b00);
    reset = 1'b0; stall = 1'b0; resume = 1'b0;

    // Underflow at STACK_BASE
    drive(2'b00, 2'b11, 16'h0000, 16'h0000); step(); check("pop_unf",  16'h0000, 16'hFFFF, 2'b10, 2'b10);
    reset = 1'b1;
    step();                                          check("reset_unf", 16'h0000, 16'hFFFF, 2'b00, 2'b00);
    reset = 1'b0;

    // Push exactly onto the limit is legal
    drive(2'b00, 2'b01, 16'h0000, 16'hF001); step(); check("setsp_f001", 16'h0001, 16'hF001, 2'b00, 2'b00);
    drive(2'b00, 2'b10, 16'h0000, 16'h0000); step(); check("push_to_lim", 16'h0002, 16'hF000, 2'b00, 2'b00);

    // Reset while halted
    drive(2'b11, 2'b00, 16'h0000, 16'h0000); step(); check("halt2",    16'h0002, 16'hF000, 2'b01, 2'b00);
    reset = 1'b1;
    step();                                          check("reset_halt", 16'h0000, 16'hFFFF, 2'b00, 2'b00);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
